alu_issue_stage: RTL and testbench

- Pipeline stage that drives the core ALU. It decodes an RV32I instruction word plus register-file operands into alu_op, operand A, operand B and writeback control.
- Sits between register read and execute. Presents registered outputs under a valid/ready handshake, with a one-entry skid buffer so throughput is one instruction per cycle under backpressure.
- Flags illegal ALU-class encodings instead of passing them through.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/alu_issue_decode.sv | 90 +++++++++
 rtl/alu_issue_stage.sv | 135 +++++++++++++
 tb/tb_alu_issue_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants for the ALU issue path.
//   - major opcodes of the ALU-class instructions
//   - 4-bit ALU operation codes, encoded as {bit30 qualifier, funct3}
//   - funct7 / funct3 values used to qualify legal encodings
package riscv_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SR      = 3'b101;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational decode of one RV32I instruction
// into ALU controls and operands.
//   instr    in   instruction word
//   pc       in   instruction address (operand A of AUIPC)
//   rs1/rs2  in   register-file operands
//   alu_op   out  {bit30 qualifier, funct3}; 0000 when illegal
//   a, b     out  ALU operands; both 0 when illegal
//   rd       out  instr[11:7], always passed through
//   wb_en    out  legal and rd != 0
//   illegal  out  not a legal ALU-class encoding
module alu_issue_decode
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic [4:0]      rd,
   output logic            wb_en,
   output logic            illegal
);

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic signed [11:0] imm_i;
   logic signed [31:0] imm_u;
   logic               legal;

   always_comb begin
      opcode = instr[6:0];
      funct3 = instr[14:12];
      funct7 = instr[31:25];
      imm_i  = instr[31:20];
      imm_u  = {instr[31:12], 12'b0};
      legal  = 1'b0;
      alu_op = ALU_ADD;
      a      = '0;
      b      = '0;

      case (opcode)
         OPC_OP: begin
            // bit30 only selects SUB / SRA; every other funct3 needs funct7 = 0
            legal  = (funct7 == F7_ZERO) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
            alu_op = {instr[30], funct3};
            a      = rs1;
            b      = rs2;
         end
         OPC_OPIMM: begin
            // bit30 is part of the immediate except for the right shifts
            case (funct3)
               F3_SLL:  legal = (funct7 == F7_ZERO);
               F3_SR:   legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
               default: legal = 1'b1;
            endcase
            alu_op = {(funct3 == F3_SR) & instr[30], funct3};
            a      = rs1;
            b      = XLEN'(imm_i);
         end
         OPC_LUI: begin
            legal = 1'b1;
            b     = XLEN'(imm_u);
         end
         OPC_AUIPC: begin
            legal = 1'b1;
            a     = pc;
            b     = XLEN'(imm_u);
         end
         default: legal = 1'b0;
      endcase

      // Illegal encodings are squashed so execute never sees junk operands
      if (!legal) begin
         alu_op = ALU_ADD;
         a      = '0;
         b      = '0;
      end

      rd      = instr[11:7];
      illegal = !legal;
      wb_en   = legal && (instr[11:7] != 5'd0);
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register-read -> execute stage for the ALU.
// Decodes the incoming instruction, then holds it in an output register
// behind a valid/ready handshake with a one-entry skid buffer.
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush, drops every held and incoming entry
//   in_valid / in_ready   upstream handshake; in_ready = !skid_valid
//   in_instr, in_pc, in_rs1_data, in_rs2_data   instruction and operands
//   out_valid / out_ready downstream handshake
//   out_alu_op, out_a, out_b, out_rd, out_wb_en, out_illegal, out_pc
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both 1. Valid never waits on ready, and while valid is high
// and ready low the payload holds still. in_ready depends only on the skid
// flag, so there is no combinational path from out_ready to in_ready.
module alu_issue_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_op,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_pc
);

   logic [3:0]      dec_alu_op;
   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic [4:0]      dec_rd;
   logic            dec_wb_en;
   logic            dec_illegal;

   logic            skid_valid;
   logic [3:0]      skid_alu_op;
   logic [XLEN-1:0] skid_a;
   logic [XLEN-1:0] skid_b;
   logic [4:0]      skid_rd;
   logic            skid_wb_en;
   logic            skid_illegal;
   logic [XLEN-1:0] skid_pc;

   logic accept;
   logic out_load;

   alu_issue_decode #(.XLEN(XLEN)) u_decode (
      .instr   (in_instr),
      .pc      (in_pc),
      .rs1     (in_rs1_data),
      .rs2     (in_rs2_data),
      .alu_op  (dec_alu_op),
      .a       (dec_a),
      .b       (dec_b),
      .rd      (dec_rd),
      .wb_en   (dec_wb_en),
      .illegal (dec_illegal)
   );

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   // Output register may take new data when empty or emptying this edge
   assign out_load = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_alu_op   <= '0;
         out_a        <= '0;
         out_b        <= '0;
         out_rd       <= '0;
         out_wb_en    <= 1'b0;
         out_illegal  <= 1'b0;
         out_pc       <= '0;
         skid_valid   <= 1'b0;
         skid_alu_op  <= '0;
         skid_a       <= '0;
         skid_b       <= '0;
         skid_rd      <= '0;
         skid_wb_en   <= 1'b0;
         skid_illegal <= 1'b0;
         skid_pc      <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_load) begin
         // skid_valid implies in_ready = 0, so no accept competes with the skid
         if (skid_valid) begin
            out_valid   <= 1'b1;
            out_alu_op  <= skid_alu_op;
            out_a       <= skid_a;
            out_b       <= skid_b;
            out_rd      <= skid_rd;
            out_wb_en   <= skid_wb_en;
            out_illegal <= skid_illegal;
            out_pc      <= skid_pc;
            skid_valid  <= 1'b0;
         end else if (accept) begin
            out_valid   <= 1'b1;
            out_alu_op  <= dec_alu_op;
            out_a       <= dec_a;
            out_b       <= dec_b;
            out_rd      <= dec_rd;
            out_wb_en   <= dec_wb_en;
            out_illegal <= dec_illegal;
            out_pc      <= in_pc;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         // Output full and stalled: park the new instruction behind it
         skid_valid   <= 1'b1;
         skid_alu_op  <= dec_alu_op;
         skid_a       <= dec_a;
         skid_b       <= dec_b;
         skid_rd      <= dec_rd;
         skid_wb_en   <= dec_wb_en;
         skid_illegal <= dec_illegal;
         skid_pc      <= in_pc;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

   localparam int XLEN = 32;
   localparam int NVEC = 14;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1_data;
   logic [XLEN-1:0] in_rs2_data;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      out_alu_op;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [4:0]      out_rd;
   logic            out_wb_en;
   logic            out_illegal;
   logic [XLEN-1:0] out_pc;

   alu_issue_stage #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_alu_op  (out_alu_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_rd      (out_rd),
      .out_wb_en   (out_wb_en),
      .out_illegal (out_illegal),
      .out_pc      (out_pc)
   );

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [3:0]  alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        wb_en;
      logic        illegal;
   } vec_t;

   vec_t vecs[NVEC];

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // scoreboard for the monitored handshake sequences (operand A tags)
   logic [XLEN-1:0] exp_q[$];
   logic            mon_en = 1'b0;
   int              xfer_count = 0;
   int              first_xfer = -1;
   int              last_xfer  = -1;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers / driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid    = 1'b1;
      in_instr    = instr;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_instr = 32'h0;
   endtask

   task automatic check_outputs(input vec_t v);
      check({v.name, "_valid"},   {31'b0, out_valid},   32'd1);
      check({v.name, "_alu_op"},  {28'b0, out_alu_op},  {28'b0, v.alu_op});
      check({v.name, "_a"},       out_a,                v.a);
      check({v.name, "_b"},       out_b,                v.b);
      check({v.name, "_rd"},      {27'b0, out_rd},      {27'b0, v.rd});
      check({v.name, "_wb_en"},   {31'b0, out_wb_en},   {31'b0, v.wb_en});
      check({v.name, "_illegal"}, {31'b0, out_illegal}, {31'b0, v.illegal});
      check({v.name, "_pc"},      out_pc,               v.pc);
   endtask

   // ---------------- scoreboard monitor ----------------
   // Inputs change just after posedge, so at negedge valid&ready predicts
   // a transfer on the coming edge with the payload currently on out_*.
   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin
         xfer_count++;
         if (first_xfer < 0) first_xfer = cycle;
         last_xfer = cycle;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_transfer actual_a=0x%08h required=none", out_a);
         end else begin
            check("sb_order_a", out_a, exp_q.pop_front());
         end
      end
   end

   // ---------------- test ----------------
   localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3,x1,x2

   initial begin
      vecs[0]  = '{"add",        32'h002081B3, 32'h00000040, 32'd5,        32'd7,        4'b0000, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0};
      vecs[1]  = '{"srai",       32'h40435293, 32'h00000044, 32'h80000000, 32'h00001234, 4'b1101, 32'h80000000, 32'h00000404, 5'd5, 1'b1, 1'b0};
      vecs[2]  = '{"lui",        32'h123450B7, 32'h00000048, 32'h11111111, 32'h22222222, 4'b0000, 32'h0,        32'h12345000, 5'd1, 1'b1, 1'b0};
      vecs[3]  = '{"auipc",      32'h00001117, 32'h00000100, 32'h11111111, 32'h22222222, 4'b0000, 32'h00000100, 32'h00001000, 5'd2, 1'b1, 1'b0};
      vecs[4]  = '{"custom0",    32'h0000000B, 32'h00000050, 32'h33333333, 32'h44444444, 4'b0000, 32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
      // funct3=001 with funct7=0100000: SLL form with the alternate funct7
      vecs[5]  = '{"sll_f7alt",  32'h402091B3, 32'h00000054, 32'd9,        32'd3,        4'b0000, 32'h0,        32'h0,        5'd3, 1'b0, 1'b1};
      // 0x402081B3 is funct3=000 with funct7=0100000, i.e. a legal SUB
      vecs[6]  = '{"sub",        32'h402081B3, 32'h00000058, 32'd20,       32'd6,        4'b1000, 32'd20,       32'd6,        5'd3, 1'b1, 1'b0};
      vecs[7]  = '{"add_rd0",    32'h00208033, 32'h0000005C, 32'd5,        32'd7,        4'b0000, 32'd5,        32'd7,        5'd0, 1'b0, 1'b0};
      vecs[8]  = '{"slli_f7alt", 32'h40431293, 32'h00000060, 32'd1,        32'd2,        4'b0000, 32'h0,        32'h0,        5'd5, 1'b0, 1'b1};
      vecs[9]  = '{"sltiu_m1",   32'hFFF0B213, 32'h00000064, 32'hABCD0000, 32'd0,        4'b0011, 32'hABCD0000, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0};
      // ADDI with imm bit 10 set: instr[30]=1 must not turn it into SUB
      vecs[10] = '{"addi_b30",   32'h40000093, 32'h00000068, 32'd3,        32'd0,        4'b0000, 32'd3,        32'h00000400, 5'd1, 1'b1, 1'b0};
      vecs[11] = '{"xor",        32'h0062C3B3, 32'h0000006C, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7, 1'b1, 1'b0};
      vecs[12] = '{"sra",        32'h4062D3B3, 32'h00000070, 32'h80000010, 32'd4,        4'b1101, 32'h80000010, 32'd4,        5'd7, 1'b1, 1'b0};
      vecs[13] = '{"beq_opc",    32'h00208063, 32'h00000074, 32'd1,        32'd1,        4'b0000, 32'h0,        32'h0,        5'd0, 1'b0, 1'b1};

      rst_n       = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b0;
      in_pc       = '0;
      in_rs1_data = '0;
      in_rs2_data = '0;
      idle_in();

      // reset state
      #22 rst_n = 1'b1;
      tick();
      check("rst_out_valid", {31'b0, out_valid},   32'd0);
      check("rst_in_ready",  {31'b0, in_ready},    32'd1);
      check("rst_alu_op",    {28'b0, out_alu_op},  32'd0);
      check("rst_a",         out_a,                32'd0);
      check("rst_b",         out_b,                32'd0);
      check("rst_rd",        {27'b0, out_rd},      32'd0);
      check("rst_wb_en",     {31'b0, out_wb_en},   32'd0);
      check("rst_illegal",   {31'b0, out_illegal}, 32'd0);
      check("rst_pc",        out_pc,               32'd0);

      // table-driven decode vectors, one per cycle with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         drive_in(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         tick();
         check_outputs(vecs[i]);
      end
      idle_in();
      tick();
      check("drain_out_valid", {31'b0, out_valid}, 32'd0);

      // backpressure: three back-to-back ADDs against a stalled consumer
      mon_en     = 1'b1;
      out_ready  = 1'b0;
      xfer_count = 0;
      first_xfer = -1;
      last_xfer  = -1;
      drive_in(ADD_X3, 32'h200, 32'd10, 32'd1);
      exp_q.push_back(32'd10);
      tick();
      check("bp1_in_ready",  {31'b0, in_ready},  32'd1);
      check("bp1_out_valid", {31'b0, out_valid}, 32'd1);
      drive_in(ADD_X3, 32'h204, 32'd11, 32'd1);
      exp_q.push_back(32'd11);
      tick();
      check("bp2_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp2_out_a",    out_a,             32'd10);
      drive_in(ADD_X3, 32'h208, 32'd12, 32'd1);
      exp_q.push_back(32'd12);
      tick();
      check("bp3_in_ready",  {31'b0, in_ready},  32'd0);
      check("bp3_out_a",     out_a,              32'd10);
      check("bp3_out_pc",    out_pc,             32'h200);
      check("bp3_out_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      check("bp4_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      idle_in();
      tick();
      tick();
      check("bp_xfer_count", xfer_count,                  32'd3);
      check("bp_queue_left", exp_q.size(),                32'd0);
      check("bp_back2back",  last_xfer - first_xfer,      32'd2);
      check("bp_end_valid",  {31'b0, out_valid},          32'd0);

      // flush with output and skid full plus a pending input
      out_ready = 1'b0;
      drive_in(ADD_X3, 32'h300, 32'd20, 32'd1);
      tick();
      drive_in(ADD_X3, 32'h304, 32'd21, 32'd1);
      tick();
      check("fl_skid_full", {31'b0, in_ready}, 32'd0);
      drive_in(ADD_X3, 32'h308, 32'd22, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_in();
      check("fl_out_valid", {31'b0, out_valid}, 32'd0);
      check("fl_in_ready",  {31'b0, in_ready},  32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fl_no_stale", {31'b0, out_valid}, 32'd0);
      end

      // flush beats an accept in the same cycle
      drive_in(ADD_X3, 32'h30C, 32'd23, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_in();
      check("fl_drop_accept", {31'b0, out_valid}, 32'd0);
      tick();
      check("fl_drop_later", {31'b0, out_valid}, 32'd0);
      mon_en = 1'b0;

      // asynchronous reset between edges with output and skid full
      out_ready = 1'b0;
      drive_in(ADD_X3, 32'h400, 32'd30, 32'd1);
      tick();
      drive_in(ADD_X3, 32'h404, 32'd31, 32'd1);
      tick();
      idle_in();
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_in_ready",  {31'b0, in_ready},  32'd1);
      check("arst_out_a",     out_a,              32'd0);
      tick();
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      drive_in(vecs[0].instr, vecs[0].pc, vecs[0].rs1, vecs[0].rs2);
      tick();
      idle_in();
      check_outputs(vecs[0]);
      tick();
      check("arst_no_skid", {31'b0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
